// File: rtl/lmfe_pkg.sv
// Shared types and constants for the lmfe window sequencer.
// FSM state enum, window geometry, pad/empty values, coordinate type.
package lmfe_pkg;

  localparam int WIN_K = 7;
  localparam int WIN_R = 3;
  localparam int WIN_N = 49;

  localparam logic [7:0] PAD_VAL   = 8'h00;
  localparam logic [7:0] EMPTY_VAL = 8'hFF;

  // Drain cycles after the last FLUSH step, minus one
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SHR,
    ST_SHL,
    ST_SHD,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef logic signed [15:0] crd_t;

endpackage

// File: rtl/lmfe_win_addr.sv
// Window step counters and pixel address generation for lmfe_win_seq.
// Ports: clk, RST, i_st (FSM state); o_addr_i/o_addr_d, o_pad_i/o_pad_d,
// o_last (window end step), o_cen/o_codd/o_cend/o_rlast (new centre info).
module lmfe_win_addr
  import lmfe_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          RST,
  input  state_t        i_st,
  output logic [AW-1:0] o_addr_i,
  output logic [AW-1:0] o_addr_d,
  output logic          o_pad_i,
  output logic          o_pad_d,
  output logic          o_last,
  output logic [AW-1:0] o_cen,
  output logic          o_codd,
  output logic          o_cend,
  output logic          o_rlast
);

  localparam logic [2:0] K_LAST = 3'(WIN_K - 1);

  logic [2:0] r_a;
  logic [2:0] r_b;
  crd_t       r_row;
  crd_t       r_col;

  int   w_row, w_col, w_oa, w_ob;
  int   w_iy, w_ix, w_dy, w_dx;
  int   w_nrow, w_ncol;
  logic w_step, w_full, w_pi, w_pd;

  function automatic logic f_out(int y, int x);
    return (y < 0) || (y >= IMG_H) || (x < 0) || (x >= IMG_W);
  endfunction

  function automatic logic [AW-1:0] f_addr(int y, int x);
    return AW'(y * IMG_W + x);
  endfunction

  always_comb begin
    w_row  = int'(r_row);
    w_col  = int'(r_col);
    w_oa   = int'(r_a) - WIN_R;
    w_ob   = int'(r_b) - WIN_R;
    w_full = (i_st == ST_FILL) || (i_st == ST_FLUSH);
    w_step = 1'b1;
    w_iy   = 0;
    w_ix   = 0;
    w_dy   = 0;
    w_dx   = 0;
    unique case (i_st)
      ST_FILL, ST_FLUSH: begin
        w_iy = w_row + w_oa;
        w_ix = w_col + w_ob;
        w_dy = w_iy;
        w_dx = w_ix;
      end
      ST_SHR: begin
        w_iy = w_row + w_ob;
        w_dy = w_iy;
        w_ix = w_col + WIN_R + 1;
        w_dx = w_col - WIN_R;
      end
      ST_SHL: begin
        w_iy = w_row + w_ob;
        w_dy = w_iy;
        w_ix = w_col - WIN_R - 1;
        w_dx = w_col + WIN_R;
      end
      ST_SHD: begin
        w_iy = w_row + WIN_R + 1;
        w_dy = w_row - WIN_R;
        w_ix = w_col + w_ob;
        w_dx = w_ix;
      end
      default: w_step = 1'b0;
    endcase
    w_nrow = w_row + ((i_st == ST_SHD) ? 1 : 0);
    w_ncol = w_col + ((i_st == ST_SHR) ? 1 : 0)
                   - ((i_st == ST_SHL) ? 1 : 0);
  end

  assign w_pi     = w_step && f_out(w_iy, w_ix);
  assign w_pd     = w_step && f_out(w_dy, w_dx);
  assign o_pad_i  = w_pi;
  assign o_pad_d  = w_pd;
  assign o_addr_i = (w_step && !w_pi) ? f_addr(w_iy, w_ix) : '0;
  assign o_addr_d = (w_step && !w_pd) ? f_addr(w_dy, w_dx) : '0;

  assign o_last  = w_step && (r_b == K_LAST)
                   && (!w_full || (r_a == K_LAST));
  assign o_cen   = f_addr(w_nrow, w_ncol);
  assign o_codd  = w_nrow[0];
  assign o_cend  = o_codd ? (w_ncol == 0) : (w_ncol == IMG_W - 1);
  assign o_rlast = (w_nrow == IMG_H - 1);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_a   <= '0;
      r_b   <= '0;
      r_row <= '0;
      r_col <= '0;
    end else if (!w_step) begin
      r_a   <= '0;
      r_b   <= '0;
      r_row <= '0;
      r_col <= '0;
    end else begin
      if (r_b == K_LAST) begin
        r_b <= '0;
        if (w_full)
          r_a <= (r_a == K_LAST) ? '0 : r_a + 3'd1;
      end else begin
        r_b <= r_b + 3'd1;
      end
      if (o_last) begin
        r_row <= crd_t'(w_nrow);
        r_col <= crd_t'(w_ncol);
      end
    end
  end

endmodule

// File: rtl/lmfe_win_seq.sv
// Serpentine 7x7 window sequencer feeding the lmfe_med49 median core.
// Ports: clk, RST, START/BUSY/DONE, ROM IADDR_*/IDATA_*, core INS/DEL/SEN, result OWEN/OADDR.
module lmfe_win_seq
  import lmfe_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] IADDR_I,
  output logic [AW-1:0] IADDR_D,
  input  logic [7:0]    IDATA_I,
  input  logic [7:0]    IDATA_D,
  output logic [7:0]    INS,
  output logic [7:0]    DEL,
  output logic          SEN,
  output logic          OWEN,
  output logic [AW-1:0] OADDR
);

  state_t     r_st;
  state_t     w_nx;
  logic [1:0] r_drn;

  logic          w_pi, w_pd, w_last;
  logic          w_codd, w_cend, w_rlast;
  logic [AW-1:0] w_cen;
  logic          w_step, w_eow;
  logic [7:0]    w_ins, w_del;

  logic          r_v1, r_pi1, r_pd1, r_fi1, r_fd1, r_e1;
  logic [AW-1:0] r_c1;
  logic          r_e2;
  logic [AW-1:0] r_c2;

  lmfe_win_addr #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .AW    (AW)
  ) u_addr (
    .clk      (clk),
    .RST      (RST),
    .i_st     (r_st),
    .o_addr_i (IADDR_I),
    .o_addr_d (IADDR_D),
    .o_pad_i  (w_pi),
    .o_pad_d  (w_pd),
    .o_last   (w_last),
    .o_cen    (w_cen),
    .o_codd   (w_codd),
    .o_cend   (w_cend),
    .o_rlast  (w_rlast)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) r_st <= ST_IDLE;
    else     r_st <= w_nx;
  end

  always_comb begin
    w_nx = r_st;
    unique case (r_st)
      ST_IDLE: if (START) w_nx = ST_FILL;
      ST_FILL, ST_SHR, ST_SHL: begin
        if (w_last) begin
          if (!w_cend)       w_nx = w_codd ? ST_SHL : ST_SHR;
          else if (!w_rlast) w_nx = ST_SHD;
          else               w_nx = ST_FLUSH;
        end
      end
      // A row change always reverses the horizontal direction
      ST_SHD:   if (w_last) w_nx = w_codd ? ST_SHL : ST_SHR;
      ST_FLUSH: if (w_last) w_nx = ST_DRAIN;
      ST_DRAIN: if (r_drn == DRAIN_LAST) w_nx = ST_DONE;
      ST_DONE:  w_nx = ST_IDLE;
      default:  w_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST)                 r_drn <= '0;
    else if (r_st == ST_DRAIN) r_drn <= r_drn + 2'd1;
    else                     r_drn <= '0;
  end

  assign BUSY   = (r_st != ST_IDLE) && (r_st != ST_DONE);
  assign DONE   = (r_st == ST_DONE);
  assign w_step = r_st inside {ST_FILL, ST_SHR, ST_SHL, ST_SHD, ST_FLUSH};
  // FLUSH completes no new window, so it never raises OWEN
  assign w_eow  = w_last && (r_st != ST_FLUSH);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_v1  <= 1'b0;
      r_pi1 <= 1'b0;
      r_pd1 <= 1'b0;
      r_fi1 <= 1'b0;
      r_fd1 <= 1'b0;
      r_e1  <= 1'b0;
      r_c1  <= '0;
    end else begin
      r_v1  <= w_step;
      r_pi1 <= w_pi;
      r_pd1 <= w_pd;
      r_fi1 <= (r_st == ST_FLUSH);
      r_fd1 <= (r_st == ST_FILL);
      r_e1  <= w_eow;
      r_c1  <= w_cen;
    end
  end

  assign w_ins = r_fi1 ? EMPTY_VAL : (r_pi1 ? PAD_VAL : IDATA_I);
  assign w_del = r_fd1 ? EMPTY_VAL : (r_pd1 ? PAD_VAL : IDATA_D);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      INS   <= EMPTY_VAL;
      DEL   <= EMPTY_VAL;
      SEN   <= 1'b1;
      r_e2  <= 1'b0;
      r_c2  <= '0;
      OWEN  <= 1'b0;
      OADDR <= '0;
    end else begin
      SEN <= !r_v1;
      if (r_v1) begin
        INS <= w_ins;
        DEL <= w_del;
      end
      r_e2 <= r_v1 && r_e1;
      r_c2 <= r_c1;
      OWEN <= r_e2;
      if (r_e2) OADDR <= r_c2;
    end
  end

endmodule

// File: tb/tb_lmfe_win_seq.sv
// Self-checking bench for lmfe_win_seq on an 8x8 image.
// Models ROM, a 49-entry multiset core, and the golden zero-padded median.
module tb_lmfe_win_seq;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 6;
  localparam int NP = W * H;
  localparam int DONE_CYC  = 49 + 63 * 7 + 49 + 3 + 1;
  localparam int FIRST_OWN = 52;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b1;
  logic          BUSY, DONE, SEN, OWEN;
  logic [AW-1:0] IADDR_I, IADDR_D, OADDR;
  logic [7:0]    IDATA_I, IDATA_D, INS, DEL;

  always #5 clk = ~clk;

  lmfe_win_seq #(
    .IMG_W (W),
    .IMG_H (H),
    .AW    (AW)
  ) dut (
    .clk     (clk),
    .RST     (RST),
    .START   (START),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .IADDR_I (IADDR_I),
    .IADDR_D (IADDR_D),
    .IDATA_I (IDATA_I),
    .IDATA_D (IDATA_D),
    .INS     (INS),
    .DEL     (DEL),
    .SEN     (SEN),
    .OWEN    (OWEN),
    .OADDR   (OADDR)
  );

  logic [7:0] img [NP];

  always @(posedge clk) begin
    IDATA_I <= img[IADDR_I];
    IDATA_D <= img[IADDR_D];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int cnt [256];
  int exp_q [$];
  int seen_q [$];
  int med_seen [NP];
  int owen_n;
  int first_cyc;
  int t0;
  bit no_owen = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int gold(input int r, input int c);
    int v [49];
    int n = 0;
    int t;
    for (int dy = -3; dy <= 3; dy++)
      for (int dx = -3; dx <= 3; dx++) begin
        int y = r + dy;
        int x = c + dx;
        if (y < 0 || y >= H || x < 0 || x >= W) v[n] = 0;
        else v[n] = int'(img[y * W + x]);
        n++;
      end
    for (int i = 1; i < 49; i++)
      for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
        t = v[j]; v[j] = v[j-1]; v[j-1] = t;
      end
    return v[24];
  endfunction

  function automatic int model_med();
    int acc = 0;
    for (int v = 0; v < 256; v++) begin
      acc += cnt[v];
      if (acc >= 25) return v;
    end
    return -1;
  endfunction

  // Core model updates at the negedge of each SEN=0 cycle, after the
  // OWEN check for that cycle, matching "MED valid one cycle later".
  task automatic mon();
    forever begin
      @(negedge clk);
      if (RST) begin
        foreach (cnt[v]) cnt[v] = 0;
        cnt[255] = 49;
      end else begin
        if (no_owen) chk("stale_owen", int'(OWEN), 0);
        else if (OWEN) begin
          int m;
          int a;
          owen_n++;
          if (owen_n == 1) first_cyc = cyc;
          a = int'(OADDR);
          seen_q.push_back(a);
          if (exp_q.size() == 0) chk("oaddr_extra", a, -1);
          else chk("oaddr_seq", a, exp_q.pop_front());
          m = model_med();
          med_seen[a] = m;
          chk("med", m, gold(a / W, a % W));
        end
        if (!SEN) begin
          checks++;
          if (cnt[DEL] == 0) begin
            errors++;
            $display("FAIL core_del got %0d absent want present", DEL);
          end else begin
            cnt[DEL]--;
          end
          cnt[INS]++;
        end
      end
    end
  endtask

  task automatic start_frame();
    exp_q.delete();
    seen_q.delete();
    for (int r = 0; r < H; r++)
      for (int k = 0; k < W; k++)
        exp_q.push_back(r * W + ((r % 2 == 0) ? k : W - 1 - k));
    owen_n = 0;
    first_cyc = -1;
    @(posedge clk); #1;
    START = 1'b1;
    t0 = cyc;
    @(negedge clk);
    chk("busy_c0", int'(BUSY), 0);
    @(posedge clk); #1;
    START = 1'b0;
    @(negedge clk);
    chk("busy_c1", int'(BUSY), 1);
  endtask

  task automatic run_frame();
    int done_c = -1;
    start_frame();
    repeat (98) @(posedge clk);
    #1 START = 1'b1;
    @(posedge clk);
    #1 START = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (DONE) begin
        done_c = cyc;
        break;
      end
    end
    if (done_c < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got none want cycle %0d", DONE_CYC);
    end else begin
      chk("done_cycle", done_c - t0, DONE_CYC);
      chk("busy_at_done", int'(BUSY), 0);
      @(negedge clk);
      chk("done_pulse", int'(DONE), 0);
    end
    chk("owen_count", owen_n, NP);
    chk("first_owen", first_cyc - t0, FIRST_OWN);
    chk("exp_left", exp_q.size(), 0);
    chk("core_restored", cnt[255], 49);
  endtask

  initial begin
    fork
      mon();
    join_none
    for (int i = 0; i < NP; i++) img[i] = 8'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sen", int'(SEN), 1);
    chk("rst_ins", int'(INS), 255);
    chk("rst_del", int'(DEL), 255);
    chk("rst_owen", int'(OWEN), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_oaddr", int'(OADDR), 0);
    chk("rst_iaddr", int'(IADDR_I), 0);
    @(posedge clk); #1;
    RST = 1'b0;
    START = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("start_in_rst", int'(BUSY), 0);
    end

    chk("gold_ramp_33", gold(3, 3), 27);
    chk("gold_ramp_30", gold(3, 0), 3);
    chk("gold_ramp_44", gold(4, 4), 36);
    run_frame();
    chk("ramp_med_27", med_seen[27], 27);
    chk("ramp_med_24", med_seen[24], 3);
    chk("ramp_med_36", med_seen[36], 36);
    if (seen_q.size() >= 17) begin
      chk("serp_7", seen_q[7], 7);
      chk("serp_8", seen_q[8], 15);
      chk("serp_15", seen_q[15], 8);
      chk("serp_16", seen_q[16], 16);
    end else begin
      chk("serp_len", seen_q.size(), NP);
    end

    for (int i = 0; i < NP; i++) img[i] = 8'h80;
    chk("gold_const_00", gold(0, 0), 0);
    chk("gold_const_33", gold(3, 3), 128);
    run_frame();
    chk("const_med_0", med_seen[0], 0);
    chk("const_med_27", med_seen[27], 128);

    for (int i = 0; i < NP; i++) img[i] = 8'($urandom_range(0, 255));
    run_frame();

    start_frame();
    for (int k = 0; k < 200 && cyc < t0 + 60; k++) @(posedge clk);
    #1;
    RST = 1'b1;
    no_owen = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_sen", int'(SEN), 1);
    chk("mid_rst_ins", int'(INS), 255);
    chk("mid_rst_busy", int'(BUSY), 0);
    chk("mid_rst_owen", int'(OWEN), 0);
    @(posedge clk); #1;
    RST = 1'b0;
    repeat (80) @(posedge clk);
    chk("mid_rst_no_done", int'(DONE), 0);
    no_owen = 1'b0;

    for (int i = 0; i < NP; i++) img[i] = 8'($urandom_range(0, 255));
    run_frame();

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
